tlat_bus_sched: RTL and testbench
=================================

Name: tlat_bus_sched

Overview:
- Sequences a bank of N transparent latch cells with output enable that share one tri-state bus.
- Per transaction the block:
  - opens the granted latch (G) to capture its data;
  - closes it;
  - drives it onto the shared bus (OE);
  - then enforces an all-off turnaround before the next driver.
- Requesters are served round-robin.
- Sits between requester logic and the latch bank; it is the only source of G/OE for the bank.

Parameters:
- N, 4, number of requesters / latch cells (2..16).
- LOAD_CYC, 1, cycles G is held high per transaction (>=1).
- DRIVE_CYC, 2, cycles OE is held high per transaction (>=1).
- TURN_CYC, 1, cycles with all OE low after a drive (>=1).

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- en  input  1  arbitration enable; low blocks new grants, an in-flight transaction completes.
- req  input  N  per-requester drive request, level-sensitive.
- g  output  N  latch gate to cell i (transparent when 1).
- oe  output  N  output enable to cell i (drives bus when 1).
- gnt  output  N  one-hot grant, owner of the current transaction.
- bus_valid  output  1  high exactly while some oe bit is high.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock CK; reset RST is asynchronous and active-high.
- Reset:
  - RST=1 forces state=IDLE, all outputs 0, RR pointer=0, counter=0, immediately and without waiting for CK.
  - This applies mid-transaction too: g/oe drop at once and the aborted requester gets no completion.
- All outputs are registered (decoded from state/owner flops), so they are glitch-free.
- States: IDLE, LOAD, HOLD, DRIVE, TURN.
- IDLE:
  - If en=1 and req!=0, pick winner w = first set req bit searching from ptr upward with wrap.
  - Next cycle: state LOAD, g[w]=1, gnt[w]=1, counter loads LOAD_CYC-1.
  - Otherwise stay in IDLE.
- LOAD: g[w]=1 for LOAD_CYC cycles, then HOLD.
- HOLD: exactly 1 cycle, g=0, oe=0, gnt[w]=1. This guarantees latch closure before drive.
- DRIVE:
  - oe[w]=1, bus_valid=1 for DRIVE_CYC cycles, then TURN.
  - ptr updates to (w+1) mod N on DRIVE entry.
- TURN:
  - All g/oe=0 and gnt=0 for TURN_CYC cycles, then IDLE.
- Transaction length = LOAD_CYC+1+DRIVE_CYC+TURN_CYC cycles plus one IDLE arbitration cycle between transactions.
- The grant is latched at arbitration. Deasserting req[w] mid-transaction has no effect; the transaction completes.
- req changes outside IDLE are ignored until the next IDLE sample.
- Invariants (assertable):
  - popcount(oe)<=1; popcount(g)<=1; popcount(gnt)<=1.
  - g[i] and oe[i] are never high together.
  - oe never goes from index i to index j!=i without at least TURN_CYC+1 all-zero cycles in between.
- Counter width is $clog2(max(LOAD_CYC,DRIVE_CYC,TURN_CYC)+1). The counter counts down and the state exits at 0.
- Single requester: the same index can be regranted back-to-back, with the same turnaround still applied.

Decomposition:
- Shared package tlat_sched_pkg holds:
  - the state enum (IDLE, LOAD, HOLD, DRIVE, TURN);
  - the localparam counter width function;
  - the default timing constants.
- One sub-module, rr_arbiter: combinational round-robin pick.
  - Inputs: req[N], ptr.
  - Outputs: one-hot winner, any.
- The FSM, counter and pointer stay in tlat_bus_sched.

Test Plan:
- Reset:
  - Assert RST asynchronously mid-DRIVE (between edges) with defaults.
  - Required: oe/g/gnt/bus_valid/busy = 0 before the next CK edge, and ptr=0 afterwards.
- Single request:
  - req=4'b0100 sampled in IDLE at cycle 0 with defaults.
  - Required: g[2]=1 cycle 1; all off cycle 2 with gnt[2]=1; oe[2]=1 and bus_valid=1 cycles 3–4; TURN cycle 5; IDLE cycle 6.
- Round-robin fairness:
  - req=4'b1111 held constant.
  - Required: oe owners in order 0,1,2,3,0, each oe window starting 6 cycles after the previous one.
  - Check the invariants on every cycle.
- Request withdrawal:
  - req[1] pulsed for one cycle at the IDLE sample.
  - Required: the full transaction for index 1 completes, with oe[1] high for 2 cycles.
- Enable gating:
  - en=0 with req=4'b0011.
  - Required: no grant, busy=0.
  - Drop en during LOAD: the transaction completes and no new grant follows until en=1.
- Parameter sweep:
  - LOAD_CYC=3, DRIVE_CYC=1, TURN_CYC=2, N=2.
  - Required: g high 3 cycles, oe 1 cycle, 2 turnaround cycles, transaction period 8 cycles under constant req.

Source files
------------

// File: rtl/tlat_sched_pkg.sv
// Shared types and timing defaults for the tri-state latch bus scheduler.
// The counter-width helper sizes the phase counter from the longest phase.
package tlat_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      HOLD  = 3'd2,
      DRIVE = 3'd3,
      TURN  = 3'd4
   } state_e;

   localparam int DEF_N         = 4;
   localparam int DEF_LOAD_CYC  = 1;
   localparam int DEF_DRIVE_CYC = 2;
   localparam int DEF_TURN_CYC  = 1;

   function automatic int cnt_width(input int load_cyc, input int drive_cyc, input int turn_cyc);
      int m;
      m = load_cyc;
      if (drive_cyc > m) begin
         m = drive_cyc;
      end
      if (turn_cyc > m) begin
         m = turn_cyc;
      end
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tlat_bus_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter
   import tlat_sched_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  win_o,
   output logic          any_o
);

   logic found_s;
   int   idx_s;

   // Rotating priority scan starting at the pointer
   always_comb begin
      win_o   = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int i = 0; i < N; i++) begin
         idx_s = (int'(ptr_i) + i) % N;
         if (!found_s && req_i[idx_s]) begin
            win_o[idx_s] = 1'b1;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/tlat_bus_sched.sv
// Sequences G/OE for a bank of transparent latches sharing one tri-state bus:
// load, hold (latch closed), drive, all-off turnaround, round-robin between requesters.
module tlat_bus_sched
   import tlat_sched_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int LOAD_CYC  = DEF_LOAD_CYC,
   parameter int DRIVE_CYC = DEF_DRIVE_CYC,
   parameter int TURN_CYC  = DEF_TURN_CYC
) (
   input  logic         CK,
   input  logic         RST,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] g,
   output logic [N-1:0] oe,
   output logic [N-1:0] gnt,
   output logic         bus_valid,
   output logic         busy
);

   localparam int CW = cnt_width(LOAD_CYC, DRIVE_CYC, TURN_CYC);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LOAD_INIT  = CW'(LOAD_CYC - 1);
   localparam logic [CW-1:0] DRIVE_INIT = CW'(DRIVE_CYC - 1);
   localparam logic [CW-1:0] TURN_INIT  = CW'(TURN_CYC - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  own_q, own_d;
   logic [IW-1:0] own_idx_q, own_idx_d;

   logic [N-1:0]  g_q, g_d;
   logic [N-1:0]  oe_q, oe_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic          bus_valid_q, bus_valid_d;
   logic          busy_q, busy_d;

   logic [N-1:0]  win_s;
   logic          any_s;
   logic [IW-1:0] win_idx_s;

   rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .win_o (win_s),
      .any_o (any_s)
   );

   // One-hot winner to index, kept so the pointer can advance past the owner
   always_comb begin
      win_idx_s = '0;
      for (int i = 0; i < N; i++) begin
         win_idx_s = win_idx_s | (win_s[i] ? IW'(i) : '0);
      end
   end

   // Next-state logic: phase sequencing, counter reload/countdown, owner and pointer
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      own_d     = own_q;
      own_idx_d = own_idx_q;
      case (state_q)
         IDLE: begin
            if (en && any_s) begin
               state_d   = LOAD;
               own_d     = win_s;
               own_idx_d = win_idx_s;
               cnt_d     = LOAD_INIT;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         HOLD: begin
            state_d = DRIVE;
            cnt_d   = DRIVE_INIT;
            ptr_d   = (own_idx_q == LAST_IDX) ? '0 : own_idx_q + IW'(1);
         end
         DRIVE: begin
            if (cnt_q == '0) begin
               state_d = TURN;
               cnt_d   = TURN_INIT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         TURN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               own_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            own_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they can be registered alongside it
   always_comb begin
      g_d         = (state_d == LOAD) ? own_d : '0;
      oe_d        = (state_d == DRIVE) ? own_d : '0;
      gnt_d       = ((state_d == LOAD) || (state_d == HOLD) || (state_d == DRIVE)) ? own_d : '0;
      bus_valid_d = (state_d == DRIVE);
      busy_d      = (state_d != IDLE);
   end

   // State, counter, pointer, owner and output registers
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ptr_q       <= '0;
         own_q       <= '0;
         own_idx_q   <= '0;
         g_q         <= '0;
         oe_q        <= '0;
         gnt_q       <= '0;
         bus_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         own_q       <= own_d;
         own_idx_q   <= own_idx_d;
         g_q         <= g_d;
         oe_q        <= oe_d;
         gnt_q       <= gnt_d;
         bus_valid_q <= bus_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign g         = g_q;
   assign oe        = oe_q;
   assign gnt       = gnt_q;
   assign bus_valid = bus_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_tlat_bus_sched.sv
// Self-checking bench: default instance (N=4,1/2/1) and a sweep instance (N=2,3/1/2)
// checked every cycle against a transaction-offset model plus directed literals.
module tb_tlat_bus_sched;

   logic       CK  = 1'b0;
   logic       RST = 1'b1;

   logic       en0  = 1'b0;
   logic [3:0] req0 = 4'b0000;
   logic [3:0] g0, oe0, gnt0;
   logic       bv0, busy0;

   logic       en1  = 1'b0;
   logic [1:0] req1 = 2'b00;
   logic [1:0] g1, oe1, gnt1;
   logic       bv1, busy1;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   always #5 CK = ~CK;

   tlat_bus_sched #(.N(4), .LOAD_CYC(1), .DRIVE_CYC(2), .TURN_CYC(1)) u_dut0 (
      .CK(CK), .RST(RST), .en(en0), .req(req0),
      .g(g0), .oe(oe0), .gnt(gnt0), .bus_valid(bv0), .busy(busy0));

   tlat_bus_sched #(.N(2), .LOAD_CYC(3), .DRIVE_CYC(1), .TURN_CYC(2)) u_dut1 (
      .CK(CK), .RST(RST), .en(en1), .req(req1),
      .g(g1), .oe(oe1), .gnt(gnt1), .bus_valid(bv1), .busy(busy1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   function automatic int p_n(input int k);   return (k == 0) ? 4 : 2; endfunction
   function automatic int p_l(input int k);   return (k == 0) ? 1 : 3; endfunction
   function automatic int p_d(input int k);   return (k == 0) ? 2 : 1; endfunction
   function automatic int p_t(input int k);   return (k == 0) ? 1 : 2; endfunction
   function automatic int p_len(input int k); return p_l(k) + 1 + p_d(k) + p_t(k); endfunction

   function automatic int pick(input logic [3:0] r, input int p, input int n);
      for (int i = 0; i < n; i++) begin
         if (r[(p + i) % n]) return (p + i) % n;
      end
      return 0;
   endfunction

   function automatic logic [3:0] oh(input int i);
      logic [3:0] v;
      v    = 4'b0000;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int oh_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   logic [3:0] req_v [2];
   logic       en_v  [2];
   logic [3:0] g_v   [2];
   logic [3:0] oe_v  [2];
   logic [3:0] gnt_v [2];
   logic       bv_v  [2];
   logic       busy_v[2];

   assign req_v[0]  = req0;           assign req_v[1]  = {2'b00, req1};
   assign en_v[0]   = en0;            assign en_v[1]   = en1;
   assign g_v[0]    = g0;             assign g_v[1]    = {2'b00, g1};
   assign oe_v[0]   = oe0;            assign oe_v[1]   = {2'b00, oe1};
   assign gnt_v[0]  = gnt0;           assign gnt_v[1]  = {2'b00, gnt1};
   assign bv_v[0]   = bv0;            assign bv_v[1]   = bv1;
   assign busy_v[0] = busy0;          assign busy_v[1] = busy1;

   // m_off: cycles since the arbitration sample (1..len), 0 when idle
   bit m_busy[2];
   int m_off [2];
   int m_own [2];
   int m_ptr [2];

   always @(posedge CK or posedge RST) begin
      for (int k = 0; k < 2; k++) begin
         if (RST) begin
            m_busy[k] <= 1'b0;
            m_off[k]  <= 0;
            m_own[k]  <= 0;
            m_ptr[k]  <= 0;
         end else if (!m_busy[k]) begin
            if (en_v[k] && (req_v[k] != 4'b0000)) begin
               m_own[k]  <= pick(req_v[k], m_ptr[k], p_n(k));
               m_busy[k] <= 1'b1;
               m_off[k]  <= 1;
            end
         end else begin
            if (m_off[k] == p_l(k) + 1) m_ptr[k] <= (m_own[k] + 1) % p_n(k);
            if (m_off[k] == p_len(k)) begin
               m_busy[k] <= 1'b0;
               m_off[k]  <= 0;
            end else begin
               m_off[k] <= m_off[k] + 1;
            end
         end
      end
   end

   function automatic bit in_win(input int k, input int lo, input int hi);
      return m_busy[k] && (m_off[k] >= lo) && (m_off[k] <= hi);
   endfunction

   int last_oe[2] = '{-1, -1};
   int zrun[2]    = '{0, 0};

   always @(negedge CK) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            logic [3:0] own;
            own = oh(m_own[k]);
            check($sformatf("m%0d_g", k),   g_v[k],   in_win(k, 1, p_l(k)) ? own : 4'b0000);
            check($sformatf("m%0d_gnt", k), gnt_v[k], in_win(k, 1, p_l(k) + 1 + p_d(k)) ? own : 4'b0000);
            check($sformatf("m%0d_oe", k),  oe_v[k],  in_win(k, p_l(k) + 2, p_l(k) + 1 + p_d(k)) ? own : 4'b0000);
            check($sformatf("m%0d_bv", k),  bv_v[k],  in_win(k, p_l(k) + 2, p_l(k) + 1 + p_d(k)));
            check($sformatf("m%0d_busy", k), busy_v[k], m_busy[k]);
            check($sformatf("inv%0d_onehot", k),
                  ($countones(g_v[k]) <= 1) && ($countones(oe_v[k]) <= 1) && ($countones(gnt_v[k]) <= 1), 1);
            check($sformatf("inv%0d_g_and_oe", k), g_v[k] & oe_v[k], 4'b0000);
            check($sformatf("inv%0d_bv_oe", k), bv_v[k], oe_v[k] != 4'b0000);
            if (oe_v[k] != 4'b0000) begin
               if ((last_oe[k] >= 0) && (oh_idx(oe_v[k]) != last_oe[k]))
                  check($sformatf("inv%0d_turnaround", k), zrun[k] >= p_t(k) + 1, 1);
               last_oe[k] = oh_idx(oe_v[k]);
               zrun[k]    = 0;
            end else begin
               zrun[k]++;
            end
         end
      end
   end

   task automatic wait_idle0();
      int t;
      t = 0;
      while (busy0 && (t < 30)) begin
         tick();
         t++;
      end
      check("idle0_timeout", busy0, 1'b0);
      tick();
   endtask

   // ---------------- directed stimulus ----------------
   int         rise_own[$];
   int         rise_cyc[$];
   logic [3:0] prev;
   int         cnt_a, cnt_b;
   logic [1:0] tg [32];
   logic [1:0] toe[32];
   logic       tbz[32];

   initial begin
      repeat (2) tick();
      RST    = 1'b0;
      chk_on = 1'b1;
      check("rst_busy", busy0, 1'b0);
      check("rst_g", g0, 4'b0000);
      check("rst_oe", oe0, 4'b0000);

      // single request to index 2: LOAD c1, HOLD c2, DRIVE c3-4, TURN c5, IDLE c6
      en0 = 1'b1; req0 = 4'b0100;
      tick(); req0 = 4'b0000;
      check("single_c1_g", g0, 4'b0100);
      check("single_c1_gnt", gnt0, 4'b0100);
      tick();
      check("single_c2_g", g0, 4'b0000);
      check("single_c2_oe", oe0, 4'b0000);
      check("single_c2_gnt", gnt0, 4'b0100);
      tick();
      check("single_c3_oe", oe0, 4'b0100);
      check("single_c3_bv", bv0, 1'b1);
      tick();
      check("single_c4_oe", oe0, 4'b0100);
      tick();
      check("single_c5_oe", oe0, 4'b0000);
      check("single_c5_gnt", gnt0, 4'b0000);
      check("single_c5_busy", busy0, 1'b1);
      tick();
      check("single_c6_busy", busy0, 1'b0);

      // async reset in the middle of a drive to index 1
      req0 = 4'b0010;
      tick(); req0 = 4'b0000;
      tick(); tick();
      check("rstm_pre_oe", oe0, 4'b0010);
      #2 RST = 1'b1;
      #1;
      check("rstm_oe", oe0, 4'b0000);
      check("rstm_g", g0, 4'b0000);
      check("rstm_gnt", gnt0, 4'b0000);
      check("rstm_bv", bv0, 1'b0);
      check("rstm_busy", busy0, 1'b0);
      tick();
      RST = 1'b0;

      // round robin from a freshly reset pointer
      req0 = 4'b1111;
      prev = 4'b0000;
      for (int c = 0; c < 30; c++) begin
         tick();
         if ((oe0 != 4'b0000) && (prev == 4'b0000)) begin
            rise_own.push_back(oh_idx(oe0));
            rise_cyc.push_back(c);
         end
         prev = oe0;
      end
      req0 = 4'b0000;
      check("rr_windows", rise_own.size() >= 5, 1);
      for (int i = 0; (i < 5) && (i < rise_own.size()); i++) begin
         check($sformatf("rr_owner%0d", i), rise_own[i], i % 4);
         if (i > 0) check($sformatf("rr_spacing%0d", i), rise_cyc[i] - rise_cyc[i-1], 6);
      end
      wait_idle0();

      // one-cycle request pulse for index 1 still yields a full transaction
      req0 = 4'b0010;
      tick(); req0 = 4'b0000;
      cnt_a = 0; cnt_b = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (oe0[1]) cnt_a++;
         if ((oe0 & 4'b1101) != 4'b0000) cnt_b++;
      end
      check("wd_oe1_cycles", cnt_a, 2);
      check("wd_other_oe", cnt_b, 0);
      wait_idle0();

      // enable gating
      en0 = 1'b0; req0 = 4'b0011;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("en_off_busy", busy0, 1'b0);
         check("en_off_gnt", gnt0, 4'b0000);
      end
      en0 = 1'b1;
      tick(); en0 = 1'b0;
      check("en_load_g", g0, 4'b0001);
      cnt_a = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (oe0[0]) cnt_a++;
      end
      check("en_drop_oe0_cycles", cnt_a, 2);
      check("en_drop_busy", busy0, 1'b0);
      check("en_drop_gnt", gnt0, 4'b0000);
      en0 = 1'b1;
      tick();
      check("en_back_gnt", gnt0, 4'b0010);
      req0 = 4'b0000;
      wait_idle0();

      // parameter sweep on the second instance, constant requests
      en1 = 1'b1; req1 = 2'b11;
      for (int c = 0; c < 32; c++) begin
         tick();
         tg[c] = g1; toe[c] = oe1; tbz[c] = busy1;
      end
      req1 = 2'b00; en1 = 1'b0;
      cnt_a = 0;
      while ((cnt_a < 32) && (tg[cnt_a] != 2'b00)) cnt_a++;
      check("sw_g_len", cnt_a, 3);
      check("sw_g_owner", tg[0], 2'b01);
      check("sw_oe_c4", toe[4], 2'b01);
      check("sw_oe_c5", toe[5], 2'b00);
      cnt_b = 0;
      for (int c = 5; (c < 32) && tbz[c] && (tg[c] == 2'b00) && (toe[c] == 2'b00); c++) cnt_b++;
      check("sw_turn_len", cnt_b, 2);
      rise_own.delete(); rise_cyc.delete();
      for (int c = 0; c < 32; c++) begin
         if ((toe[c] != 2'b00) && ((c == 0) || (toe[c-1] == 2'b00))) begin
            rise_own.push_back(oh_idx({2'b00, toe[c]}));
            rise_cyc.push_back(c);
         end
      end
      check("sw_windows", rise_own.size() >= 4, 1);
      for (int i = 0; (i < 4) && (i < rise_own.size()); i++) begin
         check($sformatf("sw_owner%0d", i), rise_own[i], i % 2);
         if (i > 0) check($sformatf("sw_period%0d", i), rise_cyc[i] - rise_cyc[i-1], 8);
      end
      cnt_a = 0;
      while (busy1 && (cnt_a < 30)) begin
         tick();
         cnt_a++;
      end
      check("idle1_timeout", busy1, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
